ma_mem_access_unit: RTL and testbench
=====================================

Name: ma_mem_access_unit

Overview:
- Memory-access (MA) stage engine. Consumes the EX/MA pipeline register outputs: mem_read, mem_write, func_3, the ALU result as the address, and DATA_2 as the store data.
- Drives a request/acknowledge data-memory port and returns sign- or zero-extended load data to the MA/WB path.
- Raises a pipeline stall while an access is outstanding, and flags misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, maximum number of cycles in BUSY waiting for dmem_ack before a bus error is reported (must be >= 1).
TMO_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter.

Ports:
CLK  input  1  clock; all state updates on the posedge.
RESET  input  1  synchronous, active-high reset.
mem_read  input  1  load request from EX/MA.
mem_write  input  1  store request from EX/MA.
func_3  input  3  RV32 load/store width and sign code.
addr  input  32  byte address (ALU result).
store_data  input  32  store operand (DATA_2).
dmem_req  output  1  memory request; registered.
dmem_we  output  1  1 = write; registered.
dmem_addr  output  32  word address, {addr[31:2],2'b00}; registered.
dmem_wdata  output  32  lane-replicated store data; registered.
dmem_byte_en  output  4  byte lane enables; registered.
dmem_ack  input  1  memory completion; rdata is valid in the same cycle as ack.
dmem_rdata  input  32  read word.
stall  output  1  freeze IF..EX/MA; combinational.
load_data  output  32  formatted load result; registered, held until the next load completes.
load_valid  output  1  one-cycle pulse when load_data updates.
access_fault  output  1  one-cycle pulse: misaligned or illegal access.
bus_error  output  1  one-cycle pulse: ack timeout.

Behaviour:
- Reset (synchronous, active-high): state IDLE; timeout counter 0; dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte_en, load_data, load_valid, access_fault and bus_error all 0.
- RESET asserted mid-access: dmem_req drops on that same edge. An ack arriving later is ignored.
- States are IDLE, BUSY and DONE.
- IDLE, op = mem_read | mem_write:
  - op with a legal, aligned access: register the dmem_* outputs and go to BUSY.
  - stall = 1 in this cycle.
  - op = 0: no action, stall = 0.
- IDLE, illegal or misaligned access: access_fault pulses on the next edge, no request is issued, stall = 0 and the state stays IDLE. Illegal or misaligned means any of:
  - mem_read and mem_write both high;
  - func_3 not in the legal sets (load: 000, 001, 010, 100, 101; store: 000, 001, 010);
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 00.
- BUSY:
  - dmem_req = 1 and stall = 1.
  - On dmem_ack: latch formatted rdata (loads only), clear dmem_req, go to DONE. load_valid pulses in DONE for loads.
  - Without ack: increment the counter. When the counter reaches TIMEOUT_CYCLES, clear dmem_req, pulse bus_error and go to DONE.
- DONE: stall = 0, so EX/MA advances at the end of this cycle. The unit must not re-issue the still-present old op. Next state is IDLE.
- Minimum access time: 3 cycles (IDLE detect, BUSY with ack, DONE); stall is high for 2 of them. Back-to-back ops therefore have a 1-cycle bubble.
- dmem_ack in IDLE or DONE is ignored.
- EX/MA inputs are held stable while stall = 1. The unit captures everything it needs at IDLE→BUSY and does not depend on that stability.
- Store lanes, with o = addr[1:0]:
  - SB: byte_en = 0001 << o; wdata = {4{store_data[7:0]}}.
  - SH: byte_en = 0011 << (2*addr[1]); wdata = {2{store_data[15:0]}}.
  - SW: byte_en = 1111; wdata = store_data.
- Loads: dmem_we = 0 and byte_en = 1111.
- Load format: select byte rdata[8*o+7 : 8*o] or halfword rdata[16*addr[1]+15 : 16*addr[1]], then:
  - LB / LH sign-extend; LBU / LHU zero-extend; LW passes through.
  - func_3 and o are taken from values captured at issue.

Decomposition:
- Shared package ma_pkg holds:
  - func_3 constants F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  - the state enum {IDLE, BUSY, DONE}.
- One combinational sub-module, ma_load_align, takes (rdata, func_3, offset) and returns the formatted 32-bit word. It is reused by the WB forwarding path later.

Test Plan:
- LB at addr 0x103, rdata 0x80_00_00_00, ack in the first BUSY cycle: dmem_addr = 0x100, load_data = 0xFFFFFF80, load_valid pulses once, stall high for exactly 2 cycles.
- LHU at addr 0x202, rdata 0xBEEF1234, ack after 4 BUSY cycles: load_data = 0x0000BEEF; stall high for 5 cycles.
- SB at addr 0x301, store_data 0x000000A5: dmem_we = 1, byte_en = 0010, wdata = 0xA5A5A5A5; load_valid stays 0.
- SW at addr 0x402: access_fault pulses, dmem_req never rises, stall stays 0.
- LW with no ack and TIMEOUT_CYCLES = 4: bus_error pulses after 4 BUSY cycles, dmem_req drops, the state returns to IDLE, and a late ack is ignored.
- RESET asserted during BUSY: next edge shows dmem_req = 0, state IDLE, all outputs 0; a new LW then completes normally.

Source files
------------

// File: rtl/ma_pkg.sv
// Shared definitions for the memory-access stage: func_3 codes, FSM states,
// the data-memory command payload and the access legality check.
package ma_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ma_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } dmem_cmd_t;

  // True when exactly one of load/store is requested with a legal, aligned func_3.
  function automatic logic access_legal(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (rd ^ wr) begin
      case (f3)
        F3_B:    ok = 1'b1;
        F3_BU:   ok = rd;
        F3_H:    ok = !off[0];
        F3_HU:   ok = rd && !off[0];
        F3_W:    ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/ma_mem_access_unit_load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module ma_load_align
  import ma_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      func_3_i,
  input  logic [1:0]      offset_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (func_3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ma_mem_access_unit.sv
// MA-stage engine: issues one request/ack data-memory access per EX/MA op,
// stalls the pipeline while it is outstanding and reports faults/timeouts.
module ma_mem_access_unit
  import ma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      func_3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [BE_W-1:0] dmem_byte_en,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid,
  output logic            access_fault,
  output logic            bus_error
);

  ma_state_e       state_q, state_d;
  dmem_cmd_t       cmd_q, cmd_d;
  logic            req_q, req_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic            load_valid_q, load_valid_d;
  logic            fault_q, fault_d;
  logic            berr_q, berr_d;

  logic            op, legal, issue, timeout_hit;
  logic [BE_W-1:0] st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] aligned;

  assign op          = mem_read | mem_write;
  assign legal       = access_legal(mem_read, mem_write, func_3, addr[1:0]);
  assign issue       = op & legal;
  assign tmo_inc     = tmo_q + TMO_W'(1);
  assign timeout_hit = (tmo_inc == TMO_W'(TIMEOUT_CYCLES));

  // Store lane enables and replicated write data for the current EX/MA op.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data;
    case (func_3)
      F3_B: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Read data is formatted with the width/offset captured at issue.
  ma_load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .func_3_i (f3_q),
    .offset_i (off_q),
    .data_o   (aligned)
  );

  always_ff @(posedge CLK) begin : state_reg
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = BUSY;
      BUSY:    if (dmem_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DONE deliberately ignores the still-present old op; EX/MA advances then.
  always_comb begin : output_logic
    stall        = 1'b0;
    req_d        = req_q;
    cmd_d        = cmd_q;
    f3_d         = f3_q;
    off_d        = off_q;
    tmo_d        = tmo_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
    berr_d       = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d   = '0;
        fault_d = op & ~legal;
        if (issue) begin
          stall       = 1'b1;
          req_d       = 1'b1;
          cmd_d.we    = mem_write;
          cmd_d.addr  = {addr[31:2], 2'b00};
          cmd_d.be    = mem_write ? st_be : 4'b1111;
          cmd_d.wdata = mem_write ? st_wdata : '0;
          f3_d        = func_3;
          off_d       = addr[1:0];
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_ack) begin
          req_d = 1'b0;
          if (!cmd_q.we) begin
            load_data_d  = aligned;
            load_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          req_d  = 1'b0;
          berr_d = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin : datapath_reg
    if (RESET) begin
      cmd_q        <= '0;
      req_q        <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      tmo_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      berr_q       <= 1'b0;
    end else begin
      cmd_q        <= cmd_d;
      req_q        <= req_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      tmo_q        <= tmo_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
      berr_q       <= berr_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = cmd_q.we;
  assign dmem_addr    = cmd_q.addr;
  assign dmem_wdata   = cmd_q.wdata;
  assign dmem_byte_en = cmd_q.be;
  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign access_fault = fault_q;
  assign bus_error    = berr_q;

endmodule

// File: tb/tb_ma_mem_access_unit.sv
// Self-checking bench for ma_mem_access_unit: directed scenarios plus randomized
// accesses compared against a byte-lane reference model.
module tb_ma_mem_access_unit;
  import ma_pkg::*;

  localparam int unsigned TMO = 4;

  logic        CLK, RESET;
  logic        mem_read, mem_write;
  logic [2:0]  func_3;
  logic [31:0] addr, store_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_en;
  logic        stall, load_valid, access_fault, bus_error;
  logic [31:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations of one access, filled by run_access.
  int          o_stall, o_req, o_lv, o_fault, o_berr, o_tail_req;
  logic        o_we;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_be;
  bit          o_hung;
  logic [31:0] exp_ld;

  ma_mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .func_3       (func_3),
    .addr         (addr),
    .store_data   (store_data),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_byte_en (dmem_byte_en),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .access_fault (access_fault),
    .bus_error    (bus_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    if (rd == wr) return 1'b0;
    if (f3[1:0] == 2'b11) return 1'b0;
    if (f3[2] && (wr || f3[1])) return 1'b0;
    return (a % m_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] o,
                                         input logic [31:0] w);
    logic [31:0] sh;
    int sz;
    sz = m_size(f3);
    if (sz == 4) return w;
    sh = w >> (8 * o);
    sh = (sz == 1) ? (sh & 32'hFF) : (sh & 32'hFFFF);
    if (!f3[2] && sh[8*sz-1]) sh = sh | (32'hFFFF_FFFF << (8 * sz));
    return sh;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] o);
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= int'(o)) && (i < int'(o) + m_size(f3));
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % m_size(f3)) +: 8];
    return w;
  endfunction

  // ---------------- stimulus driver ----------------
  // Presents one EX/MA op, holds it while stall is high, answers the request
  // with ack in BUSY cycle ack_at (0 = never), then watches 3 idle cycles.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] word, input int ack_at, input bit late_ack);
    int  busy, tail, cyc;
    bit  active, retire;
    o_stall = 0; o_req = 0; o_lv = 0; o_fault = 0; o_berr = 0; o_tail_req = 0;
    o_we = 0; o_addr = 0; o_wdata = 0; o_be = 0; o_ld = 0; o_hung = 0;
    busy = 0; tail = 0; cyc = 0; active = 1; retire = 0;
    @(negedge CLK);
    mem_read = rd; mem_write = wr; func_3 = f3; addr = a; store_data = sd;
    while (tail < 3) begin
      #1;
      if (active) begin
        if (stall) o_stall++;
        if (dmem_req) begin
          o_req++; busy++;
          o_we = dmem_we; o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_byte_en;
        end
      end else if (dmem_req) begin
        o_tail_req++;
      end
      if (load_valid) begin o_lv++; o_ld = load_data; end
      if (access_fault) o_fault++;
      if (bus_error) o_berr++;
      dmem_ack = 1'b0;
      dmem_rdata = $urandom();
      if (active && dmem_req && busy == ack_at) begin dmem_ack = 1'b1; dmem_rdata = word; end
      if (!active && tail == 0 && late_ack) dmem_ack = 1'b1;
      retire = active && !stall;
      @(negedge CLK);
      if (retire) begin
        active = 0; mem_read = 0; mem_write = 0;
        func_3 = 3'($urandom()); addr = $urandom(); store_data = $urandom();
      end else if (!active) begin
        tail++;
      end
      cyc++;
      if (cyc > 40) begin o_hung = 1; break; end
    end
    dmem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    mem_read = 0; mem_write = 0; func_3 = 0; addr = 0; store_data = 0;
    dmem_ack = 0; dmem_rdata = 0; RESET = 1;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte_en, load_data, load_valid,
         access_fault, bus_error, stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h be=%b ld=%h lv=%b af=%b be=%b st=%b, required all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte_en, load_data, load_valid,
               access_fault, bus_error, stall);
    end
    RESET = 0;
    exp_ld = 32'h0;
  endtask

  task automatic test_lb_sign;
    run_access(1, 0, F3_B, 32'h103, 32'h0, 32'h8000_0000, 1, 0);
    exp_ld = 32'hFFFF_FF80;
    n_checks++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h required %h", o_addr, 32'h100); end
    n_checks++; if (o_ld !== exp_ld) begin n_fail++; $display("FAIL lb_data: got %h required %h", o_ld, exp_ld); end
    n_checks++; if (o_lv != 1) begin n_fail++; $display("FAIL lb_valid_pulses: got %0d required 1", o_lv); end
    n_checks++; if (o_stall != 2) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d required 2", o_stall); end
    n_checks++; if (o_be !== 4'b1111 || o_we !== 1'b0) begin n_fail++; $display("FAIL lb_cmd: be=%b we=%b required be=1111 we=0", o_be, o_we); end
  endtask

  task automatic test_lhu_wait;
    run_access(1, 0, F3_HU, 32'h202, 32'h0, 32'hBEEF_1234, 4, 0);
    exp_ld = 32'h0000_BEEF;
    n_checks++; if (o_ld !== exp_ld) begin n_fail++; $display("FAIL lhu_data: got %h required %h", o_ld, exp_ld); end
    n_checks++; if (o_stall != 5) begin n_fail++; $display("FAIL lhu_stall_cycles: got %0d required 5", o_stall); end
    n_checks++; if (o_berr != 0) begin n_fail++; $display("FAIL lhu_no_bus_error: got %0d required 0", o_berr); end
  endtask

  task automatic test_sb_lanes;
    run_access(0, 1, F3_B, 32'h301, 32'h0000_00A5, $urandom(), 1, 0);
    n_checks++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b required 1", o_we); end
    n_checks++; if (o_be !== 4'b0010) begin n_fail++; $display("FAIL sb_byte_en: got %b required 0010", o_be); end
    n_checks++; if (o_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h required a5a5a5a5", o_wdata); end
    n_checks++; if (o_lv != 0) begin n_fail++; $display("FAIL sb_load_valid: got %0d required 0", o_lv); end
    n_checks++; if (load_data !== exp_ld) begin n_fail++; $display("FAIL sb_load_held: got %h required %h", load_data, exp_ld); end
  endtask

  task automatic test_sw_misaligned;
    run_access(0, 1, F3_W, 32'h402, $urandom(), $urandom(), 1, 0);
    n_checks++; if (o_fault != 1) begin n_fail++; $display("FAIL sw_fault_pulses: got %0d required 1", o_fault); end
    n_checks++; if (o_req != 0 || o_tail_req != 0) begin n_fail++; $display("FAIL sw_no_req: got %0d required 0", o_req + o_tail_req); end
    n_checks++; if (o_stall != 0) begin n_fail++; $display("FAIL sw_no_stall: got %0d required 0", o_stall); end
  endtask

  task automatic test_timeout;
    run_access(1, 0, F3_W, 32'h500, 32'h0, $urandom(), 0, 1);
    n_checks++; if (o_berr != 1) begin n_fail++; $display("FAIL tmo_bus_error: got %0d required 1", o_berr); end
    n_checks++; if (o_req != TMO) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d required %0d", o_req, TMO); end
    n_checks++; if (o_stall != TMO + 1) begin n_fail++; $display("FAIL tmo_stall_cycles: got %0d required %0d", o_stall, TMO + 1); end
    n_checks++; if (o_lv != 0 || o_tail_req != 0) begin n_fail++; $display("FAIL tmo_late_ack: lv=%0d tail_req=%0d required 0 0", o_lv, o_tail_req); end
    n_checks++; if (load_data !== exp_ld) begin n_fail++; $display("FAIL tmo_load_held: got %h required %h", load_data, exp_ld); end
    run_access(1, 0, F3_W, 32'h504, 32'h0, 32'hCAFE_F00D, 1, 0);
    exp_ld = 32'hCAFE_F00D;
    n_checks++; if (o_lv != 1 || o_ld !== exp_ld) begin n_fail++; $display("FAIL tmo_recover: lv=%0d ld=%h required 1 %h", o_lv, o_ld, exp_ld); end
  endtask

  task automatic test_reset_mid_busy;
    logic [31:0] w;
    @(negedge CLK);
    mem_read = 1; mem_write = 0; func_3 = F3_W; addr = 32'h600; dmem_ack = 0;
    @(negedge CLK); #1;
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_busy_req: got %b required 1", dmem_req); end
    RESET = 1; mem_read = 0;
    @(negedge CLK); #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte_en, load_data, load_valid,
         access_fault, bus_error, stall} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: req=%b addr=%h be=%b ld=%h st=%b, required all 0",
               dmem_req, dmem_addr, dmem_byte_en, load_data, stall);
    end
    exp_ld = 32'h0;
    RESET = 0; dmem_ack = 1; dmem_rdata = 32'h1111_2222;
    @(negedge CLK); #1;
    dmem_ack = 0;
    n_checks++; if (dmem_req !== 1'b0 || load_valid !== 1'b0 || load_data !== exp_ld) begin
      n_fail++; $display("FAIL rst_stray_ack: req=%b lv=%b ld=%h required 0 0 %h", dmem_req, load_valid, load_data, exp_ld);
    end
    w = $urandom();
    run_access(1, 0, F3_W, 32'h604, 32'h0, w, 2, 0);
    exp_ld = w;
    n_checks++; if (o_lv != 1 || o_ld !== w || o_stall != 3) begin
      n_fail++; $display("FAIL rst_then_lw: lv=%0d ld=%h stall=%0d required 1 %h 3", o_lv, o_ld, o_stall, w);
    end
  endtask

  task automatic test_random;
    bit rd, wr, legal, tmo;
    logic [2:0] f3;
    logic [31:0] a, sd, w;
    int sel, ack_at, k, e_stall, e_req, e_fault, e_berr, e_lv;
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 9);
      rd = (sel == 0) || (sel >= 2 && sel <= 5);
      wr = (sel == 0) || (sel >= 6);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = F3_B; 1: f3 = F3_H; 2: f3 = F3_W; 3: f3 = F3_BU; default: f3 = F3_HU;
        endcase
      end else begin
        f3 = 3'($urandom());
      end
      a = $urandom(); sd = $urandom(); w = $urandom();
      ack_at = $urandom_range(0, 5);
      run_access(rd, wr, f3, a, sd, w, ack_at, 1'($urandom()));

      legal = m_legal(rd, wr, f3, a);
      tmo = (ack_at == 0) || (ack_at > int'(TMO));
      k = tmo ? int'(TMO) : ack_at;
      e_stall = legal ? 1 + k : 0;
      e_req   = legal ? k : 0;
      e_fault = (!legal && (rd || wr)) ? 1 : 0;
      e_berr  = (legal && tmo) ? 1 : 0;
      e_lv    = (legal && rd && !tmo) ? 1 : 0;
      if (e_lv == 1) exp_ld = m_load(f3, a[1:0], w);

      n_checks++; if (o_hung) begin n_fail++; $display("FAIL rnd%0d hang: access did not retire within 40 cycles", it); end
      n_checks++; if (o_stall != e_stall) begin n_fail++; $display("FAIL rnd%0d stall: got %0d required %0d (rd=%b wr=%b f3=%b a=%h)", it, o_stall, e_stall, rd, wr, f3, a); end
      n_checks++; if (o_req != e_req || o_tail_req != 0) begin n_fail++; $display("FAIL rnd%0d req: got %0d/%0d required %0d/0", it, o_req, o_tail_req, e_req); end
      n_checks++; if (o_fault != e_fault) begin n_fail++; $display("FAIL rnd%0d fault: got %0d required %0d", it, o_fault, e_fault); end
      n_checks++; if (o_berr != e_berr) begin n_fail++; $display("FAIL rnd%0d bus_error: got %0d required %0d", it, o_berr, e_berr); end
      n_checks++; if (o_lv != e_lv) begin n_fail++; $display("FAIL rnd%0d load_valid: got %0d required %0d", it, o_lv, e_lv); end
      n_checks++; if (load_data !== exp_ld) begin n_fail++; $display("FAIL rnd%0d load_data: got %h required %h", it, load_data, exp_ld); end
      if (legal) begin
        n_checks++;
        if (o_addr !== {a[31:2], 2'b00} || o_we !== wr ||
            o_be !== (wr ? m_be(f3, a[1:0]) : 4'b1111)) begin
          n_fail++;
          $display("FAIL rnd%0d cmd: addr=%h we=%b be=%b required %h %b %b", it, o_addr, o_we, o_be,
                   {a[31:2], 2'b00}, wr, wr ? m_be(f3, a[1:0]) : 4'b1111);
        end
        if (wr) begin
          n_checks++;
          if (o_wdata !== m_wdata(f3, sd)) begin
            n_fail++; $display("FAIL rnd%0d wdata: got %h required %h", it, o_wdata, m_wdata(f3, sd));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb_sign();
    test_lhu_wait();
    test_sb_lanes();
    test_sw_misaligned();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
